// File: rtl/uart_tx_fifo_gen.sv
// UART transmitter with a small input FIFO.
// Configurable word width, parity, stop bits and bit prescale.
module uart_tx_fifo_gen #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int PRE_W = 6
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [WIDTH-1:0]         P_DATA,
   input  logic                     DATA_VALID,
   output logic                     DATA_READY,
   input  logic                     PAR_EN,
   input  logic                     PAR_TYP,
   input  logic                     STOP2,
   input  logic [PRE_W-1:0]         PRESCALE,
   output logic                     TX_OUT,
   output logic                     Busy,
   output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } state_t;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   state_t           r_state;
   logic [PRE_W-1:0] r_div;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_word;
   logic             r_par_en;
   logic             r_par_typ;
   logic             r_stop2;
   logic [PRE_W-1:0] r_ps;
   logic             r_tx;
   logic             r_busy;

   logic             w_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_eof;
   logic             w_tick;
   logic             w_par;
   logic [PRE_W-1:0] w_ps_in;
   logic [PRE_W-1:0] w_ps_m1;
   logic [WIDTH-1:0] w_head;
   state_t           w_state_n;
   logic [PRE_W-1:0] w_div_n;
   logic [IW-1:0]    w_idx_n;
   logic             w_tx_n;
   logic             w_busy_n;

   assign w_ready    = (r_count != CW'(DEPTH));
   assign w_push     = DATA_VALID & w_ready & ~RST;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_ps_in    = (PRESCALE == '0) ? PRE_W'(1) : PRESCALE;
   assign w_ps_m1    = r_ps - PRE_W'(1);
   assign w_tick     = (r_div == w_ps_m1);
   assign w_par      = r_par_typ ? ~^r_word : ^r_word;

   assign DATA_READY = w_ready;
   assign FIFO_COUNT = r_count;
   assign TX_OUT     = r_tx;
   assign Busy       = r_busy;

   // FIFO storage; written only on an accepted push
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= P_DATA;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Next state, bit timer, pop request and registered pin values
   always_comb begin
      w_state_n = r_state;
      w_div_n   = r_div;
      w_idx_n   = r_idx;
      w_pop     = 1'b0;
      w_eof     = 1'b0;
      w_tx_n    = 1'b1;
      w_busy_n  = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_div_n = '0;
            if (r_count != '0) begin
               w_pop     = 1'b1;
               w_state_n = S_START;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_state_n = S_DATA;
               w_idx_n   = '0;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               if (r_idx == IW'(WIDTH - 1)) begin
                  w_state_n = r_par_en ? S_PARITY : S_STOP1;
               end else begin
                  w_idx_n = r_idx + IW'(1);
               end
            end
         end
         S_PARITY: begin
            if (w_tick) begin
               w_state_n = S_STOP1;
            end
         end
         S_STOP1: begin
            if (w_tick) begin
               if (r_stop2) begin
                  w_state_n = S_STOP2;
               end else begin
                  w_eof = 1'b1;
               end
            end
         end
         S_STOP2: begin
            if (w_tick) begin
               w_eof = 1'b1;
            end
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase

      if (r_state != S_IDLE) begin
         w_div_n = w_tick ? '0 : r_div + PRE_W'(1);
      end

      if (w_eof) begin
         if (r_count != '0) begin
            w_pop     = 1'b1;
            w_state_n = S_START;
         end else begin
            w_state_n = S_IDLE;
         end
      end

      unique case (w_state_n)
         S_START:  w_tx_n = 1'b0;
         S_DATA:   w_tx_n = r_word[w_idx_n];
         S_PARITY: w_tx_n = w_par;
         default:  w_tx_n = 1'b1;
      endcase

      w_busy_n = (w_state_n != S_IDLE);
   end

   // FSM registers; frame settings are captured with the popped word
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_idx     <= '0;
         r_word    <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
         r_stop2   <= 1'b0;
         r_ps      <= PRE_W'(1);
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_div   <= w_div_n;
         r_idx   <= w_idx_n;
         r_tx    <= w_tx_n;
         r_busy  <= w_busy_n;
         if (w_pop) begin
            r_word    <= w_head;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_stop2   <= STOP2;
            r_ps      <= w_ps_in;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_gen.sv
// Directed bench for uart_tx_fifo_gen.
// Frame bit vectors list line bits first-sent at bit 0.
module tb_uart_tx_fifo_gen;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int PRE_W = 6;

   logic             CLK = 1'b0;
   logic             RST;
   logic [WIDTH-1:0] P_DATA;
   logic             DATA_VALID;
   logic             DATA_READY;
   logic             PAR_EN;
   logic             PAR_TYP;
   logic             STOP2;
   logic [PRE_W-1:0] PRESCALE;
   logic             TX_OUT;
   logic             Busy;
   logic [$clog2(DEPTH):0] FIFO_COUNT;

   int n_run  = 0;
   int n_fail = 0;

   uart_tx_fifo_gen #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .PRE_W(PRE_W)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .DATA_READY (DATA_READY),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .PRESCALE   (PRESCALE),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy),
      .FIFO_COUNT (FIFO_COUNT)
   );

   // free-running clock
   always #5 CLK = ~CLK;

   // hard stop in case the bench loses sync with the design
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // called between edges; returns at the negedge after the push edge
   task automatic send(input logic [WIDTH-1:0] w, output int waits);
      P_DATA     = w;
      DATA_VALID = 1'b1;
      waits      = 0;
      while (!DATA_READY && waits < 200) begin
         @(negedge CLK);
         waits++;
      end
      chk("send_rdy", DATA_READY, 1);
      @(posedge CLK);
      @(negedge CLK);
      DATA_VALID = 1'b0;
   endtask

   task automatic wait_busy(input string tag, output int cyc);
      cyc = 0;
      while (cyc < 64) begin
         @(posedge CLK);
         #1;
         cyc++;
         if (Busy) break;
      end
      chk({tag, "_busy_rise"}, Busy, 1);
   endtask

   // checks line bits lo..hi, ps cycles each, sampled 1ns after the edge
   task automatic frame(input string tag, input logic [15:0] bits,
                        input int ps, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         for (int c = 0; c < ps; c++) begin
            chk({tag, "_tx"}, TX_OUT, bits[i]);
            chk({tag, "_busy"}, Busy, 1);
            @(posedge CLK);
            #1;
         end
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_idle_busy"}, Busy, 0);
      chk({tag, "_idle_tx"}, TX_OUT, 1);
      chk({tag, "_idle_cnt"}, FIFO_COUNT, 0);
   endtask

   logic [WIDTH-1:0] t4w [6];
   int               wt;
   int               lat;
   int               k;
   logic             bad;

   initial begin
      t4w = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hF0, 8'h0F};

      RST        = 1'b1;
      DATA_VALID = 1'b1;
      P_DATA     = 8'hFF;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      STOP2      = 1'b0;
      PRESCALE   = 6'd1;
      repeat (3) @(negedge CLK);
      chk("rst_tx",   TX_OUT, 1);
      chk("rst_busy", Busy, 0);
      chk("rst_cnt",  FIFO_COUNT, 0);
      chk("rst_rdy",  DATA_READY, 1);
      DATA_VALID = 1'b0;
      RST        = 1'b0;
      @(negedge CLK);
      chk("rst_nopush", FIFO_COUNT, 0);

      // 0xA5, PS=1, 8N1
      send(8'hA5, wt);
      wait_busy("t1", lat);
      chk("t1_lat", lat, 1);
      frame("t1", 16'h034A, 1, 0, 9);
      idle_chk("t1");

      // 0x07, PS=4, even parity
      @(negedge CLK);
      PRESCALE = 6'd4;
      PAR_EN   = 1'b1;
      PAR_TYP  = 1'b0;
      send(8'h07, wt);
      wait_busy("t2", lat);
      frame("t2", 16'h060E, 4, 0, 10);
      idle_chk("t2");

      // 0x00, odd parity, two stop bits
      @(negedge CLK);
      PRESCALE = 6'd1;
      PAR_TYP  = 1'b1;
      STOP2    = 1'b1;
      send(8'h00, wt);
      wait_busy("t3", lat);
      frame("t3", 16'h0E00, 1, 0, 11);
      idle_chk("t3");

      // PRESCALE=0 runs as 1
      @(negedge CLK);
      PRESCALE = 6'd0;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      STOP2    = 1'b0;
      send(8'h5A, wt);
      wait_busy("ps0", lat);
      frame("ps0", 16'h02B4, 1, 0, 9);
      idle_chk("ps0");

      // six words: FIFO fills, last push stalls, frames back to back
      @(negedge CLK);
      PRESCALE = 6'd1;
      fork
         begin
            for (int j = 0; j < 5; j++) send(t4w[j], wt);
            chk("t4_full_cnt", FIFO_COUNT, 4);
            chk("t4_full_rdy", DATA_READY, 0);
            send(t4w[5], wt);
            chk("t4_stall", wt, 7);
            chk("t4_nopt_cnt", FIFO_COUNT, 4);
         end
         begin
            wait_busy("t4", lat);
            for (int j = 0; j < 6; j++)
               frame("t4", {6'b0, 1'b1, t4w[j], 1'b0}, 1, 0, 9);
            idle_chk("t4");
         end
      join

      // config change mid-frame only affects the next frame
      @(negedge CLK);
      PRESCALE = 6'd4;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      fork
         begin
            send(8'h3C, wt);
            send(8'h81, wt);
         end
         begin
            wait_busy("t5", lat);
            frame("t5a", 16'h0278, 4, 0, 4);
            PRESCALE = 6'd2;
            PAR_EN   = 1'b1;
            frame("t5a", 16'h0278, 4, 5, 9);
            frame("t5b", 16'h0502, 2, 0, 10);
            idle_chk("t5");
         end
      join

      // push landing on the end-of-frame pop edge
      @(negedge CLK);
      PRESCALE = 6'd1;
      PAR_EN   = 1'b0;
      send(8'h12, wt);
      send(8'h34, wt);
      repeat (9) @(negedge CLK);
      send(8'h56, wt);
      chk("t7_cnt", FIFO_COUNT, 1);
      chk("t7_busy", Busy, 1);
      k = 0;
      while (Busy && k < 100) begin
         @(negedge CLK);
         k++;
      end
      chk("t7_len", k, 20);
      chk("t7_cnt_end", FIFO_COUNT, 0);

      // reset during data bit 3 with two words queued
      @(negedge CLK);
      PRESCALE = 6'd4;
      fork
         begin
            send(8'hF0, wt);
            send(8'h11, wt);
            send(8'h22, wt);
         end
         begin
            wait_busy("t6", lat);
            frame("t6", 16'h03E0, 4, 0, 3);
            chk("t6_cnt_pre", FIFO_COUNT, 2);
            RST = 1'b1;
            @(posedge CLK);
            #1;
            chk("t6_tx", TX_OUT, 1);
            chk("t6_busy", Busy, 0);
            chk("t6_cnt", FIFO_COUNT, 0);
            chk("t6_rdy", DATA_READY, 1);
            RST = 1'b0;
         end
      join
      bad = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(posedge CLK);
         #1;
         if (Busy || !TX_OUT) bad = 1'b1;
      end
      chk("t6_quiet", bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
